hazard_scoreboard: RTL and testbench

//  Stall/forward controller for the 5-stage pipeline, directly downstream of the rs/rt Tuse decoders.
//  - Tracks the in-flight destination register and its Tnew for the E and M stages.
//  - Tracks the HI/LO unit (mult/div) busy countdown.
//  - Compares these records against the D-stage (used, Tuse) pairs.
//  - Produces the D-stage stall and the rs/rt forwarding selects.

---
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks E/M destination records and the HI/LO busy counter,
// and from them produces the D-stage stall and the rs/rt forwarding selects.
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic       d_rs_used,
    input  logic [1:0] d_rs_tuse,
    input  logic [4:0] d_rt,
    input  logic       d_rt_used,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_op,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;

    logic [4:0]       e_dst_q, e_dst_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       m_dst_q, m_dst_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_e_rs, hit_m_rs, hit_e_rt, hit_m_rt;
    logic stall_rs, stall_rt, stall_md;

    // Newer producer (E) shadows the older one (M) for the same register.
    function automatic logic src_stall(input logic he, input logic hm,
                                       input logic [1:0] et, input logic [1:0] mt,
                                       input logic [1:0] tuse);
        return (he && (et > tuse)) || (!he && hm && (mt > tuse));
    endfunction

    function automatic logic [1:0] src_sel(input logic he, input logic hm,
                                           input logic [1:0] et, input logic [1:0] mt);
        if (he && (et == 2'd0)) begin
            return SEL_E;
        end else if (!he && hm && (mt == 2'd0)) begin
            return SEL_M;
        end
        return SEL_RF;
    endfunction

    always_comb begin
        hit_e_rs = d_rs_used && (d_rs != 5'd0) && (e_dst_q == d_rs);
        hit_m_rs = d_rs_used && (d_rs != 5'd0) && (m_dst_q == d_rs);
        hit_e_rt = d_rt_used && (d_rt != 5'd0) && (e_dst_q == d_rt);
        hit_m_rt = d_rt_used && (d_rt != 5'd0) && (m_dst_q == d_rt);

        stall_rs = src_stall(hit_e_rs, hit_m_rs, e_tnew_q, m_tnew_q, d_rs_tuse);
        stall_rt = src_stall(hit_e_rt, hit_m_rt, e_tnew_q, m_tnew_q, d_rt_tuse);
        md_busy  = (cnt_q != '0);
        stall_md = d_md_use && md_busy;
        stall    = stall_rs || stall_rt || stall_md;

        fwd_rs_sel = src_sel(hit_e_rs, hit_m_rs, e_tnew_q, m_tnew_q);
        fwd_rt_sel = src_sel(hit_e_rt, hit_m_rt, e_tnew_q, m_tnew_q);
    end

    always_comb begin
        e_dst_d  = 5'd0;
        e_tnew_d = 2'd0;
        m_dst_d  = 5'd0;
        m_tnew_d = 2'd0;
        cnt_d    = cnt_q;

        if (!flush) begin
            m_dst_d  = e_dst_q;
            m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
            if (!stall) begin
                e_dst_d  = d_dst;
                e_tnew_d = d_tnew;
            end
        end

        // Flush kills pipeline records only; an md op already issued keeps running.
        if (d_md_op && !stall && !flush) begin
            cnt_d = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q  <= 5'd0;
            e_tnew_q <= 2'd0;
            m_dst_q  <= 5'd0;
            m_tnew_q <= 2'd0;
            cnt_q    <= '0;
        end else begin
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, md/reset sequences, and a
// randomized run against a cycle-indexed issue-history reference model.
module tb_hazard_scoreboard;

    typedef struct {
        logic [4:0] rs;
        logic       rs_used;
        logic [1:0] rs_tuse;
        logic [4:0] rt;
        logic       rt_used;
        logic [1:0] rt_tuse;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md_op;
        logic       md_div;
        logic       md_use;
        logic       flush;
        logic       exp_stall;
        logic [1:0] exp_rs;
        logic [1:0] exp_rt;
        logic       exp_busy;
    } vec_t;

    logic       clk, reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic       d_rs_used, d_rt_used, d_md_op, d_md_div, d_md_use, flush;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int total = 0;
    int bad   = 0;

    // Reference model: what was issued into E on each cycle since reset.
    int acc_dst [0:1023];
    int acc_tnew[0:1023];
    bit acc_v   [0:1023];
    bit fl_at   [0:1023];
    int rc;
    int md_done;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rs_used(d_rs_used), .d_rs_tuse(d_rs_tuse),
        .d_rt(d_rt), .d_rt_used(d_rt_used), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_op(d_md_op), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .flush(flush),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(
        input int rs, input int ru, input int rsu,
        input int rt, input int tu, input int rtu,
        input int dst, input int tn,
        input int mo, input int md, input int mu, input int fl,
        input int es, input int ers, input int ert, input int eb);
        vec_t v;
        v.rs = 5'(rs);   v.rs_used = 1'(ru); v.rs_tuse = 2'(rsu);
        v.rt = 5'(rt);   v.rt_used = 1'(tu); v.rt_tuse = 2'(rtu);
        v.dst = 5'(dst); v.tnew = 2'(tn);
        v.md_op = 1'(mo); v.md_div = 1'(md); v.md_use = 1'(mu); v.flush = 1'(fl);
        v.exp_stall = 1'(es); v.exp_rs = 2'(ers); v.exp_rt = 2'(ert); v.exp_busy = 1'(eb);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rs_used = v.rs_used; d_rs_tuse = v.rs_tuse;
        d_rt = v.rt; d_rt_used = v.rt_used; d_rt_tuse = v.rt_tuse;
        d_dst = v.dst; d_tnew = v.tnew;
        d_md_op = v.md_op; d_md_div = v.md_div; d_md_use = v.md_use; flush = v.flush;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic es, input logic [1:0] ers,
                           input logic [1:0] ert, input logic eb);
        chk({nm, ".stall"}, 8'(stall), 8'(es));
        chk({nm, ".rs_sel"}, 8'(fwd_rs_sel), 8'(ers));
        chk({nm, ".rt_sel"}, 8'(fwd_rt_sel), 8'(ert));
        chk({nm, ".md_busy"}, 8'(md_busy), 8'(eb));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Producer issued on cycle a is in E on a+1 (full tnew left) and in M on a+2
    // (one cycle consumed), unless a flush on a+1 wiped it.
    task automatic src_eval(input int s, input bit used, input int tuse,
                            input bit ev, input int ed, input int et,
                            input bit mv, input int md, input int mt,
                            output bit st, output int sel);
        st = 0; sel = 0;
        if (used && s != 0) begin
            if (ev && ed == s) begin
                st  = (et > tuse);
                sel = (et == 0) ? 1 : 0;
            end else if (mv && md == s) begin
                st  = (mt > tuse);
                sel = (mt == 0) ? 2 : 0;
            end
        end
    endtask

    task automatic model_step(input vec_t v, output vec_t r);
        bit ev, mv, st_rs, st_rt, busy;
        int ed, et, md, mt, srs, srt;
        ev = 0; mv = 0; ed = 0; et = 0; md = 0; mt = 0;
        if (rc >= 1 && acc_v[rc-1]) begin
            ev = 1; ed = acc_dst[rc-1]; et = acc_tnew[rc-1];
        end
        if (rc >= 2 && acc_v[rc-2] && !fl_at[rc-1]) begin
            mv = 1; md = acc_dst[rc-2]; mt = (acc_tnew[rc-2] > 0) ? acc_tnew[rc-2] - 1 : 0;
        end
        src_eval(int'(v.rs), v.rs_used, int'(v.rs_tuse), ev, ed, et, mv, md, mt, st_rs, srs);
        src_eval(int'(v.rt), v.rt_used, int'(v.rt_tuse), ev, ed, et, mv, md, mt, st_rt, srt);
        busy = (rc <= md_done);
        r = v;
        r.exp_stall = st_rs | st_rt | (v.md_use & busy);
        r.exp_rs = 2'(srs);
        r.exp_rt = 2'(srt);
        r.exp_busy = busy;
        fl_at[rc] = v.flush;
        acc_v[rc] = !r.exp_stall && !v.flush;
        acc_dst[rc] = int'(v.dst);
        acc_tnew[rc] = int'(v.tnew);
        if (v.md_op && acc_v[rc]) md_done = rc + (v.md_div ? 10 : 5);
        rc++;
    endtask

    vec_t tbl[22];

    initial begin
        vec_t v, r;
        int n;

        tbl[0]  = mk(0,0,0,  0,0,0,  8,2, 0,0,0,0, 0,0,0,0);
        tbl[1]  = mk(8,1,0,  0,0,0,  0,0, 0,0,0,0, 1,0,0,0);
        tbl[2]  = mk(8,1,0,  0,0,0,  0,0, 0,0,0,0, 1,0,0,0);
        tbl[3]  = mk(8,1,0,  0,0,0,  0,0, 0,0,0,0, 0,0,0,0);
        tbl[4]  = mk(0,0,0,  0,0,0,  9,1, 0,0,0,0, 0,0,0,0);
        tbl[5]  = mk(9,1,1,  0,0,0, 10,1, 0,0,0,0, 0,0,0,0);
        tbl[6]  = mk(9,1,0, 10,1,0,  0,0, 0,0,0,0, 1,2,0,0);
        tbl[7]  = mk(9,1,0, 10,1,0,  0,0, 0,0,0,0, 0,0,2,0);
        tbl[8]  = mk(0,0,0,  0,0,0, 31,0, 0,0,0,0, 0,0,0,0);
        tbl[9]  = mk(0,0,0, 31,1,0, 10,1, 0,0,0,0, 0,0,1,0);
        tbl[10] = mk(0,0,0, 31,1,0, 10,1, 0,0,0,0, 0,0,2,0);
        tbl[11] = mk(10,1,1,10,1,0,  0,0, 0,0,0,0, 1,0,0,0);
        tbl[12] = mk(0,0,0, 10,1,0,  0,0, 0,0,0,0, 0,0,2,0);
        tbl[13] = mk(0,0,0,  0,0,0,  4,2, 0,0,0,0, 0,0,0,0);
        tbl[14] = mk(0,0,0,  0,0,0,  0,0, 0,0,0,1, 0,0,0,0);
        tbl[15] = mk(4,1,0,  4,1,2,  0,0, 0,0,0,0, 0,0,0,0);
        tbl[16] = mk(0,1,0,  0,1,0,  0,0, 0,0,0,0, 0,0,0,0);
        tbl[17] = mk(0,0,0,  0,0,0,  7,2, 0,0,0,0, 0,0,0,0);
        tbl[18] = mk(7,1,0,  0,0,0,  0,0, 0,0,0,1, 1,0,0,0);
        tbl[19] = mk(7,1,0,  0,0,0,  0,0, 0,0,0,0, 0,0,0,0);
        tbl[20] = mk(0,0,0,  0,0,0,  3,0, 0,0,0,1, 0,0,0,0);
        tbl[21] = mk(3,1,0,  0,0,0,  0,0, 0,0,0,0, 0,0,0,0);

        reset = 1'b0;
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0));
        repeat (2) @(negedge clk);
        chk_all("reset_state", 1'b0, 2'd0, 2'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].exp_stall, tbl[i].exp_rs,
                    tbl[i].exp_rt, tbl[i].exp_busy);
        end

        // HI/LO busy: mflo right behind div/mult stalls for exactly the unit latency.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            @(negedge clk);
            drive(mk(0,0,0, 0,0,0, 0,0, 1,(k==0)?1:0,1,0, 0,0,0,0));
            #1;
            chk_all($sformatf("md_issue%0d", k), 1'b0, 2'd0, 2'd0, 1'b0);
            n = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                drive(mk(0,0,0, 0,0,0, 0,0, 0,0,1,0, 0,0,0,0));
                #1;
                if (!stall) break;
                n++;
            end
            chk($sformatf("md_stall_cycles%0d", k), 8'(n), (k == 0) ? 8'd10 : 8'd5);
            chk($sformatf("md_busy_after%0d", k), 8'(md_busy), 8'd0);
        end

        // Async reset mid-div with a live forwarding record.
        do_reset();
        @(negedge clk);
        drive(mk(0,0,0, 0,0,0, 0,0, 1,1,1,0, 0,0,0,0));
        @(negedge clk);
        drive(mk(0,0,0, 0,0,0, 5,0, 0,0,0,0, 0,0,0,0));
        #1;
        chk_all("rst_pre_a", 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        drive(mk(5,1,0, 5,1,0, 0,0, 0,0,1,0, 0,0,0,0));
        #1;
        chk_all("rst_pre_b", 1'b1, 2'd1, 2'd1, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized run against the issue-history model.
        do_reset();
        rc = 0;
        md_done = -100;
        for (int i = 0; i < 1024; i++) begin
            acc_v[i] = 0; fl_at[i] = 0; acc_dst[i] = 0; acc_tnew[i] = 0;
        end
        for (int i = 0; i < 900; i++) begin
            v = mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0);
            v.rs = 5'($urandom_range(0, 3));
            v.rs_used = 1'($urandom_range(0, 1));
            v.rs_tuse = 2'($urandom_range(0, 1));
            v.rt = 5'($urandom_range(0, 3));
            v.rt_used = 1'($urandom_range(0, 1));
            v.rt_tuse = 2'($urandom_range(0, 2));
            v.dst = 5'($urandom_range(0, 3));
            v.tnew = 2'($urandom_range(0, 2));
            v.md_op = ($urandom_range(0, 15) == 0);
            v.md_div = 1'($urandom_range(0, 1));
            v.md_use = v.md_op | ($urandom_range(0, 4) == 0);
            v.flush = ($urandom_range(0, 11) == 0);
            @(negedge clk);
            drive(v);
            model_step(v, r);
            #1;
            chk_all($sformatf("rnd%0d", i), r.exp_stall, r.exp_rs, r.exp_rt, r.exp_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
